// File: rtl/sudoku_mask_iter_if.sv
// sudoku_mask_iter_if: puzzle request and result handshake bundle for sudoku_mask_iter
interface sudoku_mask_iter_if #(
    parameter int ITER_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [728:0]      in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [728:0]      mask_out;
    logic [323:0]      puzzle_out;
    logic              solved;
    logic              conflict;
    logic              stalled;
    logic              timeout;
    logic [ITER_W-1:0] iter_count;
    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, mask_out, puzzle_out, solved, conflict, stalled, timeout, iter_count
    );
    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, mask_out, puzzle_out, solved, conflict, stalled, timeout, iter_count
    );
endinterface

// File: rtl/sudoku_mask_iter.sv
// sudoku_mask_iter: drives a combinational mask stage until solved/conflict/stall/timeout.
// Define SUDOKU_ITER_CONFLICT_EN to build in per-cell conflict detection.
module sudoku_mask_iter #(
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    sudoku_mask_iter_if.slave bus,
    output logic [728:0]      stg_mask_out,
    input  logic [728:0]      stg_mask_in
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]        state;
    logic [728:0]      mask_reg;
    logic [ITER_W-1:0] iter_q, iter_nxt;
    logic              solved_q, conflict_q, stalled_q, timeout_q;
    logic [80:0]       cell_single;
    logic [323:0]      puzzle;
    logic              any_conflict, all_single, is_stall, is_timeout, done_now;

    function automatic logic [3:0] decode(input logic [8:0] m);
        logic [8:0] f;
        f = ~m;
        decode = 4'd0;
        for (int d = 0; d < 9; d++)
            if (f == 9'(1 << d)) decode = 4'(d + 1);
    endfunction

    always_comb begin
        cell_single = '0;
        for (int c = 0; c < 81; c++) cell_single[c] = $countones(stg_mask_in[c*9 +: 9]) == 8;
    end

`ifdef SUDOKU_ITER_CONFLICT_EN
    logic [80:0] cell_conflict;
    always_comb begin
        cell_conflict = '0;
        for (int c = 0; c < 81; c++) cell_conflict[c] = &stg_mask_in[c*9 +: 9];
    end
    assign any_conflict = |cell_conflict;
`else
    assign any_conflict = 1'b0;
`endif

    assign all_single = &cell_single;
    assign is_stall   = stg_mask_in == mask_reg;
    assign iter_nxt   = iter_q + ITER_W'(1);
    assign is_timeout = iter_nxt == ITER_W'(MAX_ITER);
    assign done_now   = any_conflict | all_single | is_stall | is_timeout;

    always_comb begin
        puzzle = '0;
        for (int c = 0; c < 81; c++) puzzle[c*4 +: 4] = decode(mask_reg[c*9 +: 9]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mask_reg   <= '0;
            iter_q     <= '0;
            solved_q   <= 1'b0;
            conflict_q <= 1'b0;
            stalled_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            state      <= RUN;
            mask_reg   <= bus.in_mask;
            iter_q     <= '0;
            solved_q   <= 1'b0;
            conflict_q <= 1'b0;
            stalled_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (state == RUN) begin
            // flags only become nonzero on the terminating pass, so writing them every pass is safe
            mask_reg   <= stg_mask_in;
            iter_q     <= iter_nxt;
            conflict_q <= any_conflict;
            solved_q   <= !any_conflict && all_single;
            stalled_q  <= !any_conflict && !all_single && is_stall;
            timeout_q  <= !any_conflict && !all_single && !is_stall && is_timeout;
            state      <= done_now ? DONE : RUN;
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end
    end

    assign stg_mask_out   = mask_reg;
    assign bus.in_ready   = state == IDLE && !rst;
    assign bus.out_valid  = state == DONE;
    assign bus.mask_out   = mask_reg;
    assign bus.puzzle_out = puzzle;
    assign bus.solved     = solved_q;
    assign bus.conflict   = conflict_q;
    assign bus.stalled    = stalled_q;
    assign bus.timeout    = timeout_q;
    assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_sudoku_mask_iter.sv
// tb_sudoku_mask_iter: directed checks of sudoku_mask_iter with a behavioural mask stage.
module tb_sudoku_mask_iter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [728:0] stg_mask_out, stg_mask_in;
    logic         grow = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           lat;
    logic [728:0] grid_mask, hold_mask;
    logic [323:0] grid_puzzle;

    sudoku_mask_iter_if #(.ITER_W(6)) bus ();

    sudoku_mask_iter #(.MAX_ITER(4), .ITER_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stg_mask_out (stg_mask_out),
        .stg_mask_in  (stg_mask_in)
    );

    // identity stage, or one that sets the lowest clear bit per pass
    assign stg_mask_in = grow ? (stg_mask_out | (stg_mask_out + 729'd1)) : stg_mask_out;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_puzzle(input logic [728:0] m, output int l);
        bus.in_mask  = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        l = 1;
        while (!bus.out_valid && l < 50) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);
    endtask

    function automatic logic [3:0] flags();
        return {bus.solved, bus.conflict, bus.stalled, bus.timeout};
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b0;
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++) begin
                int v;
                v = (x + 3 * (y % 3) + y / 3) % 9;
                grid_mask[(x*9+y)*9 +: 9]   = ~(9'b1 << v);
                grid_puzzle[(x*9+y)*4 +: 4] = 4'(v + 1);
            end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_low", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_iter", bus.iter_count, 0);
        chk("rst_flags", flags(), 4'b0000);
        chk("rst_mask", bus.mask_out, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", bus.in_ready, 1);

        // solved grid
        grow = 1'b0;
        run_puzzle(grid_mask, lat);
        chk("solved_latency", lat, 2);
        chk("solved_out_valid", bus.out_valid, 1);
        chk("solved_flags", flags(), 4'b1000);
        chk("solved_iter", bus.iter_count, 1);
        chk("solved_puzzle", bus.puzzle_out, grid_puzzle);
        chk("solved_mask", bus.mask_out, grid_mask);
        release_result();

        // cell (0,0) fully eliminated
        run_puzzle(729'h1ff, lat);
`ifdef SUDOKU_ITER_CONFLICT_EN
        chk("conflict_flags", flags(), 4'b0100);
`else
        chk("conflict_flags", flags(), 4'b0010);
`endif
        chk("conflict_iter", bus.iter_count, 1);
        chk("conflict_cell0", bus.puzzle_out[3:0], 0);
        release_result();

        // all-zero stall
        run_puzzle('0, lat);
        chk("stall_latency", lat, 2);
        chk("stall_flags", flags(), 4'b0010);
        chk("stall_iter", bus.iter_count, 1);
        chk("stall_puzzle", bus.puzzle_out, 0);

        // backpressure while holding the stall result
        hold_mask = bus.mask_out;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_mask  = {729{1'b1}};
            @(posedge clk);
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_mask", bus.mask_out, hold_mask);
            chk("bp_flags", flags(), 4'b0010);
            chk("bp_iter", bus.iter_count, 1);
        end
        bus.in_valid = 1'b0;
        release_result();

        // timeout: one new bit per pass, MAX_ITER=4
        grow = 1'b1;
        run_puzzle('0, lat);
        chk("timeout_latency", lat, 5);
        chk("timeout_flags", flags(), 4'b0001);
        chk("timeout_iter", bus.iter_count, 4);
        chk("timeout_popcount", $countones(bus.mask_out), 4);
        chk("timeout_mask", bus.mask_out, 729'hf);
        release_result();

        // reset mid-RUN
        bus.in_mask  = '0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_iter", bus.iter_count, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_in_ready", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_out_valid", bus.out_valid, 0);
        chk("midrun_flags", flags(), 4'b0000);
        chk("midrun_iter0", bus.iter_count, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_in_ready", bus.in_ready, 1);
        chk("midrun_no_result", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
